// File: rtl/bus_arb_dec.sv
// Native-bus fabric: round-robin arbitration of NUM_MSTR masters onto one shared
// slave port, mask/base decode to NUM_SLV slaves, and response timeout with error reporting.
module bus_arb_dec #(
    parameter int                    NUM_MSTR    = 2,
    parameter int                    NUM_SLV     = 4,
    parameter logic [32*NUM_SLV-1:0] SLV_BASE    = {NUM_SLV{32'h0}},
    parameter logic [32*NUM_SLV-1:0] SLV_MASK    = {NUM_SLV{32'hFF00_0000}},
    parameter int                    TIMEOUT_CYC = 255,
    parameter logic [31:0]           ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_MSTR-1:0]      mstr_valid_i,
    input  logic [32*NUM_MSTR-1:0]   mstr_addr_i,
    input  logic [32*NUM_MSTR-1:0]   mstr_wdata_i,
    input  logic [4*NUM_MSTR-1:0]    mstr_wstrb_i,
    output logic [32*NUM_MSTR-1:0]   mstr_rdata_o,
    output logic [NUM_MSTR-1:0]      mstr_ready_o,
    output logic [NUM_SLV-1:0]       slv_valid_o,
    output logic [31:0]              slv_addr_o,
    output logic [31:0]              slv_wdata_o,
    output logic [3:0]               slv_wstrb_o,
    input  logic [32*NUM_SLV-1:0]    slv_rdata_i,
    input  logic [NUM_SLV-1:0]       slv_ready_i,
    output logic                     err_o,
    output logic [31:0]              err_addr_o,
    output logic [7:0]               err_cnt_o
);

    localparam int MW = (NUM_MSTR > 1) ? $clog2(NUM_MSTR) : 1;
    localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [MW-1:0] PTR_RST  = MW'(NUM_MSTR - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] last_grant;
    logic [MW-1:0] grant_idx;
    logic [MW-1:0] rr_cand;
    logic          grant_found;
    logic [SW-1:0] sel;
    logic [SW-1:0] hit_idx;
    logic          hit;
    logic [TW-1:0] tmo_cnt;
    logic          go_resp;
    logic          resp_err;
    logic [31:0]   resp_data;
    logic [MW-1:0] resp_mstr;
    logic [31:0]   g_addr;

    logic [31:0] m_addr  [NUM_MSTR];
    logic [31:0] m_wdata [NUM_MSTR];
    logic [3:0]  m_wstrb [NUM_MSTR];
    logic [31:0] rdata_q [NUM_MSTR];
    logic [31:0] s_rdata [NUM_SLV];

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    for (genvar g = 0; g < NUM_MSTR; g++) begin : g_mstr
        assign m_addr[g]  = mstr_addr_i[32*g +: 32];
        assign m_wdata[g] = mstr_wdata_i[32*g +: 32];
        assign m_wstrb[g] = mstr_wstrb_i[4*g +: 4];
        assign mstr_rdata_o[32*g +: 32] = rdata_q[g];
    end

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_slv
        assign s_rdata[g] = slv_rdata_i[32*g +: 32];
    end

    // Round robin: walk from last_grant downwards in distance so the nearest
    // requester after last_grant overwrites the farther ones.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_cand     = '0;
        for (int i = NUM_MSTR; i >= 1; i--) begin
            rr_cand = MW'((int'(last_grant) + i) % NUM_MSTR);
            if (mstr_valid_i[rr_cand]) begin
                grant_found = 1'b1;
                grant_idx   = rr_cand;
            end
        end
    end

    assign g_addr = m_addr[grant_idx];

    // Descending scan so the lowest matching slave index wins on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int j = NUM_SLV - 1; j >= 0; j--) begin
            if ((g_addr & SLV_MASK[32*j +: 32]) == SLV_BASE[32*j +: 32]) begin
                hit     = 1'b1;
                hit_idx = SW'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go_resp   = 1'b0;
        resp_err  = 1'b0;
        resp_data = ERR_DATA;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    if (hit) begin
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = RESP;
                        go_resp   = 1'b1;
                        resp_err  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (slv_ready_i[sel]) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                    resp_data = s_rdata[sel];
                end else if (TIMEOUT_CYC != 0 && tmo_cnt == TMO_LAST) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // An unmapped request answers straight from IDLE, before last_grant is updated.
    assign resp_mstr = (state == IDLE) ? grant_idx : last_grant;

    always_comb begin
        slv_valid_o = '0;
        if (state == ACCESS) begin
            slv_valid_o[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant   <= PTR_RST;
            sel          <= '0;
            slv_addr_o   <= '0;
            slv_wdata_o  <= '0;
            slv_wstrb_o  <= '0;
            tmo_cnt      <= '0;
            mstr_ready_o <= '0;
            err_o        <= 1'b0;
            err_addr_o   <= '0;
            err_cnt_o    <= '0;
            for (int i = 0; i < NUM_MSTR; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            mstr_ready_o <= '0;
            err_o        <= 1'b0;

            if (state == IDLE && grant_found) begin
                last_grant  <= grant_idx;
                sel         <= hit_idx;
                slv_addr_o  <= g_addr;
                slv_wdata_o <= m_wdata[grant_idx];
                slv_wstrb_o <= m_wstrb[grant_idx];
            end

            if (state == ACCESS) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= '0;
            end

            if (go_resp) begin
                mstr_ready_o[resp_mstr] <= 1'b1;
                rdata_q[resp_mstr]      <= resp_data;
                if (resp_err) begin
                    err_o      <= 1'b1;
                    err_addr_o <= (state == IDLE) ? g_addr : slv_addr_o;
                    err_cnt_o  <= sat_inc8(err_cnt_o);
                end
            end
        end
    end

endmodule
